// File: rtl/mem_rw_pkg.sv
// Shared types and helpers for the paged inter-step memory read path.
package mem_rw_pkg;

    localparam int NENT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_e;

    // Bits needed to index `value` items; never returns less than 1.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_reader_fifo.sv
// Small sync FIFO holding returned entries plus their last tag; head is read from registered storage.
// Push and pop in the same cycle leave the count unchanged; pop on empty is ignored.
module mem_reader_fifo
    import mem_rw_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                        clka,
    input  logic                        rstb,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic [clogb2(DEPTH+1)-1:0]  count
);

    localparam int PTW = clogb2(DEPTH);
    localparam int CW  = clogb2(DEPTH+1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTW-1:0]   wr_ptr;
    logic [PTW-1:0]   rd_ptr;
    logic             do_pop;

    function automatic logic [PTW-1:0] ptr_next(input logic [PTW-1:0] p);
        return (p == PTW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count != '0);
    assign dout   = store[rd_ptr];

    always_ff @(posedge clka) begin
        if (push) store[wr_ptr] <= din;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_next(wr_ptr);
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The reader's credit rule must make this unreachable.
    a_no_overflow: assert property (@(posedge clka) disable iff (rstb)
        !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/mem_page_reader.sv
// Streams one BRAM page out as a ready/valid burst with a last flag, hiding the fixed read latency.
// First read the cycle after start; reads are issued only while FIFO space covers all reads in flight.
module mem_page_reader
    import mem_rw_pkg::*;
#(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int NPAGES       = 8,
    parameter int PAGE_DEPTH   = RAM_DEPTH / NPAGES,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                           clka,
    input  logic                           rstb,
    input  logic                           start,
    input  logic [clogb2(NPAGES)-1:0]      page,
    input  logic [NENT_WIDTH*NPAGES-1:0]   nent_i,
    output logic [clogb2(RAM_DEPTH)-1:0]   addrb,
    output logic                           enb,
    input  logic [RAM_WIDTH-1:0]           mem_dout,
    output logic [RAM_WIDTH-1:0]           out_data,
    output logic                           out_valid,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int PW  = clogb2(NPAGES);
    localparam int PDW = clogb2(PAGE_DEPTH);
    localparam int IW  = PDW + 1;
    localparam int CW  = clogb2(FIFO_DEPTH+1);

    rd_state_e                state_q, state_d;
    logic [PW-1:0]            page_q;
    logic [IW-1:0]            n_q, idx_q, n_sel;
    logic [NENT_WIDTH-1:0]    nent_sel;
    logic [READ_LATENCY-1:0]  infl_q, last_q;
    logic                     issue_last;
    logic                     credit;
    logic [CW-1:0]            fifo_count;
    logic [RAM_WIDTH:0]       fifo_dout;

    assign nent_sel = nent_i[NENT_WIDTH*int'(page) +: NENT_WIDTH];
    assign n_sel    = (int'(nent_sel) > PAGE_DEPTH) ? IW'(PAGE_DEPTH) : IW'(nent_sel);
    assign credit   = (int'(fifo_count) + $countones(infl_q)) < FIFO_DEPTH;

    always_comb begin
        state_d    = state_q;
        enb        = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ISSUE;
            ISSUE: begin
                if (n_q == '0) begin
                    state_d = DONE;
                end else if (credit) begin
                    enb        = 1'b1;
                    issue_last = (idx_q == n_q - 1'b1);
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: if ((infl_q == '0) && (fifo_count == '0)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q <= IDLE;
            page_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            infl_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                page_q <= page;
                n_q    <= n_sel;
                idx_q  <= '0;
            end else if (enb) begin
                idx_q <= idx_q + 1'b1;
            end
            // Issued-read flags age one stage per cycle; the tail lines up with mem_dout.
            for (int i = READ_LATENCY-1; i > 0; i--) begin
                infl_q[i] <= infl_q[i-1];
                last_q[i] <= last_q[i-1];
            end
            infl_q[0] <= enb;
            last_q[0] <= issue_last;
        end
    end

    assign addrb = enb ? {page_q, idx_q[PDW-1:0]} : '0;

    mem_reader_fifo #(
        .WIDTH (RAM_WIDTH+1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka  (clka),
        .rstb  (rstb),
        .push  (infl_q[READ_LATENCY-1]),
        .din   ({last_q[READ_LATENCY-1], mem_dout}),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_dout[RAM_WIDTH-1:0] : '0;
    assign out_last  = out_valid && fifo_dout[RAM_WIDTH];
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_page_reader.sv
// Directed bench: two readers (read latency 2 and 1) against a behavioural paged BRAM.
module tb_mem_page_reader;

    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic [63:0] nent;
    logic        start_s [2];
    logic [2:0]  page_s  [2];
    logic [9:0]  addrb_s [2];
    logic        enb_s   [2];
    logic [17:0] dout_s  [2];
    logic [17:0] od_s    [2];
    logic        ov_s    [2];
    logic        ol_s    [2];
    logic        ordy_s  [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [17:0] mem [1024];

    int errors = 0;
    int checks = 0;
    int cur = 0;
    logic [9:0]  addrs [$];
    logic [18:0] beats [$];
    int done_cnt = 0;
    int hold_viol = 0;
    bit hv = 1'b0;
    logic [18:0] hd = '0;
    int a0, b0, d0, h0;
    bit enb_at1;

    always #5 clka = ~clka;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            logic [17:0] p1 = '0;
            logic [17:0] p2 = '0;
            mem_page_reader #(.READ_LATENCY(2-g)) u_dut (
                .clka      (clka),
                .rstb      (rstb),
                .start     (start_s[g]),
                .page      (page_s[g]),
                .nent_i    (nent),
                .addrb     (addrb_s[g]),
                .enb       (enb_s[g]),
                .mem_dout  (dout_s[g]),
                .out_data  (od_s[g]),
                .out_valid (ov_s[g]),
                .out_last  (ol_s[g]),
                .out_ready (ordy_s[g]),
                .busy      (busy_s[g]),
                .done      (done_s[g])
            );
            always @(posedge clka) begin
                if (enb_s[g]) p1 <= mem[addrb_s[g]];
                p2 <= p1;
            end
            assign dout_s[g] = (g == 0) ? p2 : p1;
        end
    endgenerate

    always @(negedge clka) begin
        if (enb_s[cur]) addrs.push_back(addrb_s[cur]);
        if (ov_s[cur] && ordy_s[cur]) beats.push_back({ol_s[cur], od_s[cur]});
        if (done_s[cur]) done_cnt++;
        if (hv && !rstb && (!ov_s[cur] || ({ol_s[cur], od_s[cur]} !== hd))) hold_viol++;
        hv = ov_s[cur] && !ordy_s[cur];
        hd = {ol_s[cur], od_s[cur]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s rl%0d: observed 0x%0h expected 0x%0h", tag, 2-cur, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs(input int d);
        return 64'({addrb_s[d], enb_s[d], ov_s[d], ol_s[d], busy_s[d], done_s[d], od_s[d]});
    endfunction

    task automatic run_page(input int d, input logic [2:0] pg, input bit rnd, input bit poke,
                            input int maxcyc, output int cyc);
        bit seen;
        seen = 1'b0;
        a0 = addrs.size(); b0 = beats.size(); d0 = done_cnt; h0 = hold_viol;
        page_s[d] = pg; start_s[d] = 1'b1;
        @(posedge clka); #1;
        start_s[d] = 1'b0; cyc = 1; enb_at1 = enb_s[d];
        while (!seen && cyc < maxcyc) begin
            if (done_s[d]) begin
                seen = 1'b1;
                if (poke) start_s[d] = 1'b1;
            end else begin
                if (rnd) ordy_s[d] = ($urandom_range(0, 99) < 30);
                if (poke && cyc == 2) begin
                    nent[23:16] = 8'd9; page_s[d] = 3'd3; start_s[d] = 1'b1;
                end
                if (poke && cyc == 3) start_s[d] = 1'b0;
                @(posedge clka); #1;
                cyc++;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge clka); #1;
        start_s[d] = 1'b0; ordy_s[d] = 1'b1;
        repeat (4) @(posedge clka);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        int bad;
        bad = 0;
        chk({tag, "_nbeats"}, 64'(beats.size() - b0), 64'(n));
        chk({tag, "_nreads"}, 64'(addrs.size() - a0), 64'(n));
        for (int i = 0; i < n && b0 + i < beats.size(); i++)
            if (beats[b0+i] !== {(i == n-1), mem[base+i]}) bad++;
        for (int i = 0; i < n && a0 + i < addrs.size(); i++)
            if (addrs[a0+i] !== 10'(base + i)) bad++;
        chk({tag, "_bad_entries"}, 64'(bad), 64'd0);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; page_s[i] = '0; ordy_s[i] = 1'b1;
        end
        nent = '0;
        for (int a = 0; a < 1024; a++) mem[a] = {8'h5A, 10'(a)};
        for (int i = 0; i < 5; i++) mem[384+i] = 18'h100 + 18'(i);

        for (int d = 0; d < 2; d++) begin
            int rl;
            int cyc;
            int k;
            rl = 2 - d;
            cur = d;
            rstb = 1'b1;
            nent = {8'd200, 8'd4, 8'd10, 8'd0, 8'd5, 8'd6, 8'd20, 8'd0};
            repeat (3) @(posedge clka);
            #1;
            chk("reset_outputs", all_outs(d), 64'd0);
            rstb = 1'b0;

            // page 3: 5 prefilled entries, full-rate drain
            run_page(d, 3'd3, 1'b0, 1'b0, 100, cyc);
            chk("p3_first_enb", 64'(enb_at1), 64'd1);
            chk("p3_first_addr", 64'(addrs[a0]), 64'd384);
            chk("p3_first_beat", 64'(beats[b0]), 64'h00100);
            chk("p3_last_beat", 64'(beats[b0+4]), 64'h40104);
            chk("p3_done_cycle", 64'(cyc), 64'(5 + rl + 3));
            check_stream("p3", 384, 5);

            // empty page: no reads, done two cycles after start
            run_page(d, 3'd0, 1'b0, 1'b0, 20, cyc);
            chk("p0_done_cycle", 64'(cyc), 64'd2);
            check_stream("p0", 0, 0);

            // entry count above page size is clipped to 128
            run_page(d, 3'd7, 1'b0, 1'b0, 400, cyc);
            check_stream("p7", 896, 128);
            chk("p7_last_addr", 64'(addrs[a0+127]), 64'd1023);
            chk("p7_done_cycle", 64'(cyc), 64'(128 + rl + 3));

            // sparse downstream ready
            run_page(d, 3'd1, 1'b1, 1'b0, 2000, cyc);
            check_stream("p1", 128, 20);
            chk("p1_hold_stable", 64'(hold_viol - h0), 64'd0);

            // start while busy / in DONE ignored, nent change mid-page ignored
            run_page(d, 3'd2, 1'b0, 1'b1, 100, cyc);
            check_stream("p2", 256, 6);
            chk("p2_busy_after", 64'(busy_s[d]), 64'd0);

            // reset while the third beat of page 5 is presented
            page_s[d] = 3'd5; start_s[d] = 1'b1;
            b0 = beats.size();
            @(posedge clka); #1;
            start_s[d] = 1'b0;
            k = 0;
            while (!((beats.size() - b0 == 2) && ov_s[d]) && k < 50) begin
                @(posedge clka); #1;
                k++;
            end
            chk("p5_third_beat_seen", 64'(k < 50), 64'd1);
            chk("p5_third_beat_data", 64'(od_s[d]), 64'(mem[642]));
            rstb = 1'b1;
            @(posedge clka); #1;
            chk("rst_mid_outputs", all_outs(d), 64'd0);
            rstb = 1'b0;
            b0 = beats.size(); a0 = addrs.size();
            repeat (6) @(posedge clka);
            #1;
            chk("rst_inflight_dropped", 64'((beats.size() - b0) + (addrs.size() - a0)), 64'd0);
            run_page(d, 3'd6, 1'b0, 1'b0, 100, cyc);
            check_stream("p6_after_rst", 768, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
